// File: rtl/timeout_pkg.sv
// Shared types for the timeout scheduler: duration width, duration type, per-channel state.
package timeout_pkg;

    localparam int unsigned DEFAULT_SEC_W = 10;

    typedef logic [DEFAULT_SEC_W-1:0] sec_t;

    typedef enum logic {
        CH_IDLE  = 1'b0,
        CH_ARMED = 1'b1
    } ch_state_e;

endpackage

// File: rtl/timeout_scheduler_if.sv
// Requester-side bus of the timeout scheduler.
// TIMEOUT_RELOAD_EN adds the per-channel periodic_i request qualifier.
interface timeout_scheduler_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SEC_W  = 10
);
    logic [NUM_CH-1:0]       req_i;
    logic [NUM_CH*SEC_W-1:0] dur_i;
    logic [NUM_CH-1:0]       cancel_i;
    logic [NUM_CH-1:0]       grant_o;
    logic [NUM_CH-1:0]       active_o;
    logic [NUM_CH-1:0]       expired_o;
`ifdef TIMEOUT_RELOAD_EN
    logic [NUM_CH-1:0]       periodic_i;

    modport master (output req_i, dur_i, cancel_i, periodic_i,
                    input  grant_o, active_o, expired_o);
    modport slave  (input  req_i, dur_i, cancel_i, periodic_i,
                    output grant_o, active_o, expired_o);
`else
    modport master (output req_i, dur_i, cancel_i,
                    input  grant_o, active_o, expired_o);
    modport slave  (input  req_i, dur_i, cancel_i,
                    output grant_o, active_o, expired_o);
`endif
endinterface

// File: rtl/timeout_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at a registered pointer.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int unsigned PW = $clog2(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_n;

    // First requester at or after the pointer, wrapping; silent while in reset.
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < int'(N); i++) begin
            idx = PW'((int'(ptr_q) + i) % int'(N));
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        if (!rst_n) grant = '0;
    end

    always_comb begin
        ptr_n = ptr_q;
        if (advance) begin
            for (int i = 0; i < int'(N); i++) begin
                if (grant[i]) ptr_n = (i == int'(N) - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_n;
    end
endmodule

// File: rtl/timeout_scheduler.sv
// Per-channel seconds countdowns sharing one 1 Hz tick, armed through a round-robin arbiter.
// Optional TIMEOUT_RELOAD_EN: periodic channels reload their stored duration on expiry.
module timeout_scheduler
    import timeout_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SEC_W  = DEFAULT_SEC_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_i,
    timeout_scheduler_if.slave  bus
);
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] xfer;
    logic [NUM_CH-1:0] active_v;
    logic [NUM_CH-1:0] expired_v;

    assign eligible = bus.req_i & ~bus.cancel_i;
    assign xfer     = grant & bus.req_i;

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (eligible),
        .advance (|xfer),
        .grant   (grant)
    );

    for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_ch
        ch_state_e        state_q, state_n;
        logic [SEC_W-1:0] rem_q, rem_n;
        logic [SEC_W-1:0] dur;
        logic             exp_q, exp_n;
        logic             act_b, exp_b;
`ifdef TIMEOUT_RELOAD_EN
        logic             per_q, per_n;
        logic [SEC_W-1:0] ld_q, ld_n;
`endif

        assign dur = bus.dur_i[k*SEC_W +: SEC_W];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= CH_IDLE;
                rem_q   <= '0;
                exp_q   <= 1'b0;
`ifdef TIMEOUT_RELOAD_EN
                per_q   <= 1'b0;
                ld_q    <= '0;
`endif
            end else begin
                state_q <= state_n;
                rem_q   <= rem_n;
                exp_q   <= exp_n;
`ifdef TIMEOUT_RELOAD_EN
                per_q   <= per_n;
                ld_q    <= ld_n;
`endif
            end
        end

        // Priority cancel > arm > tick; an arm loads the new duration undecremented.
        always_comb begin
            state_n = state_q;
            rem_n   = rem_q;
            exp_n   = 1'b0;
`ifdef TIMEOUT_RELOAD_EN
            per_n   = per_q;
            ld_n    = ld_q;
`endif
            if (bus.cancel_i[k]) begin
                state_n = CH_IDLE;
                rem_n   = '0;
            end else if (xfer[k]) begin
`ifdef TIMEOUT_RELOAD_EN
                per_n = bus.periodic_i[k];
                ld_n  = dur;
`endif
                if (dur != '0) begin
                    state_n = CH_ARMED;
                    rem_n   = dur;
                end else begin
                    state_n = CH_IDLE;
                    rem_n   = '0;
                    exp_n   = 1'b1;
                end
            end else if (tick_i && state_q == CH_ARMED) begin
                if (rem_q > SEC_W'(1)) begin
                    rem_n = rem_q - SEC_W'(1);
                end else begin
                    exp_n = 1'b1;
`ifdef TIMEOUT_RELOAD_EN
                    if (per_q) begin
                        rem_n = ld_q;
                    end else begin
                        state_n = CH_IDLE;
                        rem_n   = '0;
                    end
`else
                    state_n = CH_IDLE;
                    rem_n   = '0;
`endif
                end
            end
        end

        always_comb begin
            act_b = (state_q == CH_ARMED);
            exp_b = exp_q;
        end

        assign active_v[k]  = act_b;
        assign expired_v[k] = exp_b;
    end

    assign bus.grant_o   = grant;
    assign bus.active_o  = active_v;
    assign bus.expired_o = expired_v;
endmodule
